alu_responder: RTL and testbench

ALU_RESPONDER -- requirements
Module: alu_responder

---
 rtl/dut_pkg.sv | 47 ++++
 rtl/alu_divider.sv | 81 ++++++++
 rtl/alu_responder.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dut_pkg.sv
// Shared types and constants for the ALU responder: operation codes,
// error codes and the controller state encoding.
package dut_pkg;

    typedef enum logic [7:0] {
        OP_NOP = 8'd0,
        OP_ADD = 8'd1,
        OP_AND = 8'd2,
        OP_XOR = 8'd3,
        OP_MUL = 8'd4,
        OP_DIV = 8'd5,
        OP_LDA = 8'd6,
        OP_STA = 8'd7,
        OP_MOV = 8'd8,
        OP_SWP = 8'd9,
        OP_WMR = 8'd10
    } operation_t;

    localparam logic [7:0] ERR_NONE    = 8'd0;
    localparam logic [7:0] ERR_ILLEGAL = 8'd1;
    localparam logic [7:0] ERR_DIVZERO = 8'd2;
    localparam logic [7:0] ERR_PREFIX  = 8'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXEC     = 3'd1,
        MUL_WAIT = 3'd2,
        DIV_RUN  = 3'd3,
        SWP_WB   = 3'd4,
        DONE     = 3'd5
    } state_t;

    // "Greater than zero" flag for a 64-bit result; signed view when sgn=1.
    function automatic logic result_gp(input logic [63:0] value, input logic sgn,
                                       input logic [7:0] code);
        logic flag;
        if (code != ERR_NONE) begin
            flag = 1'b0;
        end else if (sgn) begin
            flag = ($signed(value) > 64'sd0);
        end else begin
            flag = (value != 64'd0);
        end
        return flag;
    endfunction

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider, one quotient bit per cycle. Signed operands
// are reduced to magnitudes on start and the signs reapplied on the outputs:
// quotient truncates toward zero, remainder follows the dividend sign.
module alu_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic        busy_r;
    logic        done_r;
    logic [5:0]  cnt_r;
    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] dvs_r;
    logic        neg_q_r;
    logic        neg_r_r;

    logic [31:0] abs_dividend_s;
    logic [31:0] abs_divisor_s;
    logic [32:0] rem_sh_s;
    logic [33:0] diff_s;
    logic        fits_s;

    // Operand magnitudes and one restoring trial-subtraction step.
    always_comb begin
        abs_dividend_s = (sgn && dividend[31]) ? (32'd0 - dividend) : dividend;
        abs_divisor_s  = (sgn && divisor[31])  ? (32'd0 - divisor)  : divisor;
        rem_sh_s       = {rem_r, quo_r[31]};
        diff_s         = {1'b0, rem_sh_s} - {2'b00, dvs_r};
        fits_s         = ~diff_s[33];
    end

    // Load on start, then shift/subtract for 32 cycles and pulse done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cnt_r   <= 6'd0;
            rem_r   <= 32'd0;
            quo_r   <= 32'd0;
            dvs_r   <= 32'd0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (start) begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            cnt_r   <= 6'd32;
            rem_r   <= 32'd0;
            quo_r   <= abs_dividend_s;
            dvs_r   <= abs_divisor_s;
            neg_q_r <= sgn && (dividend[31] ^ divisor[31]);
            neg_r_r <= sgn && dividend[31];
        end else if (busy_r) begin
            rem_r <= fits_s ? diff_s[31:0] : rem_sh_s[31:0];
            quo_r <= {quo_r[30:0], fits_s};
            cnt_r <= cnt_r - 6'd1;
            if (cnt_r == 6'd1) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = neg_q_r ? (32'd0 - quo_r) : quo_r;
    assign remainder = neg_r_r ? (32'd0 - rem_r) : rem_r;

endmodule

// File: rtl/alu_responder.sv
// Command-driven ALU with a small internal word memory. A command is
// captured from IDLE, executed with an op-dependent latency and answered
// by a one-cycle done pulse carrying result, error code and gp flag.
module alu_responder
    import dut_pkg::*;
#(
    parameter int MEM_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  op,
    input  logic        op_prefix,
    input  logic        sv,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        done,
    output logic [63:0] result,
    output logic [7:0]  err,
    output logic        gp
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_t      state_r, state_next_s;
    logic [7:0]  op_r;
    logic        prefix_r;
    logic        sv_r;
    logic [31:0] a_r, b_r;
    logic [63:0] result_r;
    logic [7:0]  err_r;
    logic        gp_r;
    logic        done_r;
    logic [31:0] mem_r [MEM_DEPTH];

    logic [63:0] mul_a_r, mul_b_r, prod_r;
    logic        mul_phase_r;

    logic [AW-1:0] addr_a_s, addr_b_s;
    logic [63:0]   ext_a_s, ext_b_s;
    logic [63:0]   res_next_s;
    logic [7:0]    err_next_s;
    logic          gp_next_s;
    logic          we0_s, we1_s;
    logic [AW-1:0] wa0_s, wa1_s;
    logic [31:0]   wd0_s, wd1_s;
    logic          mul_load_s;
    logic          div_start_s;
    logic          div_busy_s, div_done_s;
    logic [31:0]   div_quo_s, div_rem_s;

    assign addr_a_s = a_r[AW-1:0];
    assign addr_b_s = b_r[AW-1:0];
    assign ext_a_s  = sv_r ? {{32{a_r[31]}}, a_r} : {32'd0, a_r};
    assign ext_b_s  = sv_r ? {{32{b_r[31]}}, b_r} : {32'd0, b_r};

    alu_divider u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start_s),
        .sgn       (sv_r),
        .dividend  (a_r),
        .divisor   (b_r),
        .busy      (div_busy_s),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Next state, command result and memory write controls.
    always_comb begin
        state_next_s = state_r;
        res_next_s   = 64'd0;
        err_next_s   = ERR_NONE;
        we0_s        = 1'b0;
        wa0_s        = addr_a_s;
        wd0_s        = 32'd0;
        we1_s        = 1'b0;
        wa1_s        = addr_b_s;
        wd1_s        = 32'd0;
        mul_load_s   = 1'b0;
        div_start_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: begin
                state_next_s = DONE;
                if (prefix_r) begin
                    err_next_s = ERR_PREFIX;
                end else begin
                    case (op_r)
                        OP_NOP: res_next_s = 64'd0;
                        OP_ADD: res_next_s = ext_a_s + ext_b_s;
                        OP_AND: res_next_s = {32'd0, a_r & b_r};
                        OP_XOR: res_next_s = {32'd0, a_r ^ b_r};
                        OP_MUL: begin
                            mul_load_s   = 1'b1;
                            state_next_s = MUL_WAIT;
                        end
                        OP_DIV: begin
                            if (b_r == 32'd0) begin
                                err_next_s = ERR_DIVZERO;
                            end else begin
                                div_start_s  = 1'b1;
                                state_next_s = DIV_RUN;
                            end
                        end
                        OP_LDA: res_next_s = {32'd0, mem_r[addr_a_s]};
                        OP_STA: begin
                            we0_s = 1'b1;
                            wd0_s = b_r;
                        end
                        OP_MOV: begin
                            we0_s      = 1'b1;
                            wd0_s      = mem_r[addr_b_s];
                            res_next_s = {32'd0, mem_r[addr_b_s]};
                        end
                        OP_SWP: state_next_s = SWP_WB;
                        OP_WMR: begin
                            we0_s      = 1'b1;
                            wd0_s      = b_r;
                            res_next_s = {32'd0, mem_r[addr_a_s]};
                        end
                        default: err_next_s = ERR_ILLEGAL;
                    endcase
                end
            end
            MUL_WAIT: begin
                if (mul_phase_r) begin
                    res_next_s   = prod_r;
                    state_next_s = DONE;
                end else begin
                    state_next_s = MUL_WAIT;
                end
            end
            DIV_RUN: begin
                if (div_done_s) begin
                    res_next_s   = {div_rem_s, div_quo_s};
                    state_next_s = DONE;
                end else if (!div_busy_s) begin
                    // Divider lost its command: recover rather than hang.
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DIV_RUN;
                end
            end
            SWP_WB: begin
                // With equal addresses both ports write back the same word.
                we0_s        = 1'b1;
                wd0_s        = mem_r[addr_b_s];
                we1_s        = 1'b1;
                wd1_s        = mem_r[addr_a_s];
                res_next_s   = {mem_r[addr_a_s], mem_r[addr_b_s]};
                state_next_s = DONE;
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
        gp_next_s = result_gp(res_next_s, sv_r, err_next_s);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Command capture from IDLE; operands are frozen until the next capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r     <= 8'd0;
            prefix_r <= 1'b0;
            sv_r     <= 1'b0;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
        end else if (state_r == IDLE && start) begin
            op_r     <= op;
            prefix_r <= op_prefix;
            sv_r     <= sv;
            a_r      <= A;
            b_r      <= B;
        end
    end

    // Multiplier pipeline: extended operands, then product, then result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_a_r     <= 64'd0;
            mul_b_r     <= 64'd0;
            prod_r      <= 64'd0;
            mul_phase_r <= 1'b0;
        end else begin
            prod_r <= mul_a_r * mul_b_r;
            if (mul_load_s) begin
                mul_a_r     <= ext_a_s;
                mul_b_r     <= ext_b_s;
                mul_phase_r <= 1'b0;
            end else begin
                mul_phase_r <= (state_r == MUL_WAIT);
            end
        end
    end

    // Output registers, loaded on entry to DONE and held until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_r <= 64'd0;
            err_r    <= ERR_NONE;
            gp_r     <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= (state_next_s == DONE);
            if (state_next_s == DONE) begin
                result_r <= res_next_s;
                err_r    <= err_next_s;
                gp_r     <= gp_next_s;
            end
        end
    end

    // Data memory with two write ports used by the swap write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else begin
            if (we0_s) begin
                mem_r[wa0_s] <= wd0_s;
            end
            if (we1_s) begin
                mem_r[wa1_s] <= wd1_s;
            end
        end
    end

    assign done   = done_r;
    assign result = result_r;
    assign err    = err_r;
    assign gp     = gp_r;

endmodule

// File: tb/tb_alu_responder.sv
// Self-checking bench for alu_responder: directed vector table, randomized
// commands against a behavioural model, held-start and mid-divide reset.
module tb_alu_responder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  op;
    logic        op_prefix;
    logic        sv;
    logic [31:0] A, B;
    logic        done;
    logic [63:0] result;
    logic [7:0]  err;
    logic        gp;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [DEPTH];

    alu_responder #(.MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .op_prefix(op_prefix),
        .sv(sv), .A(A), .B(B), .done(done), .result(result), .err(err), .gp(gp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic        pfx;
        logic        sv;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        logic [7:0]  err;
        logic        gp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one command, scramble inputs after capture, measure latency.
    task automatic run_cmd(input logic [7:0] c_op, input logic c_pfx, input logic c_sv,
                           input logic [31:0] c_a, input logic [31:0] c_b,
                           output logic [63:0] r, output logic [7:0] e,
                           output logic g, output int lat);
        @(negedge clk);
        start = 1'b1; op = c_op; op_prefix = c_pfx; sv = c_sv; A = c_a; B = c_b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = 8'($urandom); op_prefix = 1'($urandom);
        sv = 1'($urandom); A = $urandom; B = $urandom;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        if (!done) lat = -1;
        r = result; e = err; g = gp;
        @(negedge clk);
        @(posedge clk); #1;
        check("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    // Behavioural model computed from the operation definitions.
    task automatic model(input logic [7:0] m_op, input logic m_pfx, input logic m_sv,
                         input logic [31:0] m_a, input logic [31:0] m_b,
                         output logic [63:0] r, output logic [7:0] e,
                         output logic g, output int lat);
        longint xa, xb, q, rm;
        int unsigned ma, mb;
        logic [31:0] tmp;
        xa = m_sv ? longint'($signed(m_a)) : longint'({32'd0, m_a});
        xb = m_sv ? longint'($signed(m_b)) : longint'({32'd0, m_b});
        ma = m_a % DEPTH;
        mb = m_b % DEPTH;
        r = 64'd0; e = 8'd0; lat = 1;
        if (m_pfx) e = 8'd3;
        else if (m_op > 8'd10) e = 8'd1;
        else begin
            case (m_op)
                8'd1: r = xa + xb;
                8'd2: r = {32'd0, m_a & m_b};
                8'd3: r = {32'd0, m_a ^ m_b};
                8'd4: begin r = xa * xb; lat = 3; end
                8'd5: begin
                    if (m_b == 32'd0) e = 8'd2;
                    else begin
                        q = xa / xb; rm = xa % xb; lat = 34;
                        r = {rm[31:0], q[31:0]};
                    end
                end
                8'd6: r = {32'd0, ref_mem[ma]};
                8'd7: ref_mem[ma] = m_b;
                8'd8: begin r = {32'd0, ref_mem[mb]}; ref_mem[ma] = ref_mem[mb]; end
                8'd9: begin
                    lat = 2; r = {ref_mem[ma], ref_mem[mb]};
                    tmp = ref_mem[ma]; ref_mem[ma] = ref_mem[mb]; ref_mem[mb] = tmp;
                end
                8'd10: begin r = {32'd0, ref_mem[ma]}; ref_mem[ma] = m_b; end
                default: r = 64'd0;
            endcase
        end
        if (e != 8'd0) g = 1'b0;
        else if (m_sv) g = ($signed(r) > 64'sd0);
        else g = (r != 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r, er;
        logic [7:0]  e, ee;
        logic        g, eg;
        int          lat, el, pulses, wide, prev, spurious;
        logic [7:0]  rop;
        logic        rpfx, rsv;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; op = 8'd0; op_prefix = 1'b0; sv = 1'b0;
        A = 32'd0; B = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_err", {56'd0, err}, 64'd0);
        check("reset_gp", {63'd0, gp}, 64'd0);
        @(negedge clk); reset = 1'b0;

        // op, pfx, sv, A, B, result, err, gp, latency
        vecs.push_back('{8'd1, 1'b0, 1'b1, 32'hFFFFFFFB, 32'd3, 64'hFFFFFFFFFFFFFFFE, 8'd0, 1'b0, 1});
        vecs.push_back('{8'd4, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, 64'h00000001FFFFFFFE, 8'd0, 1'b1, 3});
        vecs.push_back('{8'd5, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFFFFFFFFFD, 8'd0, 1'b0, 34});
        vecs.push_back('{8'd5, 1'b0, 1'b1, 32'd5, 32'd0, 64'd0, 8'd2, 1'b0, 1});
        vecs.push_back('{8'd7, 1'b0, 1'b0, 32'd3, 32'h55, 64'd0, 8'd0, 1'b0, 1});
        vecs.push_back('{8'd10, 1'b0, 1'b0, 32'd3, 32'hAA, 64'h55, 8'd0, 1'b1, 1});
        vecs.push_back('{8'd9, 1'b0, 1'b0, 32'd3, 32'd4, 64'h000000AA00000000, 8'd0, 1'b1, 2});
        vecs.push_back('{8'd6, 1'b0, 1'b0, 32'd4, 32'd0, 64'hAA, 8'd0, 1'b1, 1});
        vecs.push_back('{8'd11, 1'b0, 1'b0, 32'd1, 32'd2, 64'd0, 8'd1, 1'b0, 1});
        vecs.push_back('{8'd1, 1'b1, 1'b0, 32'd1, 32'd2, 64'd0, 8'd3, 1'b0, 1});
        vecs.push_back('{8'd5, 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000, 8'd0, 1'b1, 34});
        vecs.push_back('{8'd9, 1'b0, 1'b0, 32'd4, 32'd20, 64'h000000AA000000AA, 8'd0, 1'b1, 2});
        vecs.push_back('{8'd6, 1'b0, 1'b0, 32'd4, 32'd0, 64'hAA, 8'd0, 1'b1, 1});
        vecs.push_back('{8'd8, 1'b0, 1'b0, 32'd5, 32'd4, 64'hAA, 8'd0, 1'b1, 1});
        vecs.push_back('{8'd6, 1'b0, 1'b0, 32'd21, 32'd0, 64'hAA, 8'd0, 1'b1, 1});
        vecs.push_back('{8'd3, 1'b0, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 64'h0FF00FF0, 8'd0, 1'b1, 1});
        vecs.push_back('{8'd2, 1'b0, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 64'hF000F000, 8'd0, 1'b1, 1});
        vecs.push_back('{8'd0, 1'b0, 1'b0, 32'd9, 32'd9, 64'd0, 8'd0, 1'b0, 1});
        vecs.push_back('{8'd4, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFFFFFFFFFE, 8'd0, 1'b0, 3});
        vecs.push_back('{8'd5, 1'b0, 1'b0, 32'd7, 32'd2, 64'h0000000100000003, 8'd0, 1'b1, 34});

        foreach (vecs[i]) begin
            run_cmd(vecs[i].op, vecs[i].pfx, vecs[i].sv, vecs[i].a, vecs[i].b, r, e, g, lat);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_err", i), {56'd0, e}, {56'd0, vecs[i].err});
            check($sformatf("vec%0d_gp", i), {63'd0, g}, {63'd0, vecs[i].gp});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        // Memory contents left behind by the table.
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
        ref_mem[4] = 32'hAA;
        ref_mem[5] = 32'hAA;

        for (int n = 0; n < 80; n++) begin
            rop  = 8'($urandom_range(0, 12));
            rpfx = ($urandom_range(0, 15) == 0);
            rsv  = 1'($urandom);
            ra   = $urandom;
            rb   = $urandom;
            if (rop == 8'd5 && $urandom_range(0, 7) == 0) rb = 32'd0;
            if (rop == 8'd5 && $urandom_range(0, 9) == 0) begin
                ra = 32'h80000000; rb = 32'hFFFFFFFF;
            end
            if (rop >= 8'd6 && $urandom_range(0, 3) == 0) rb = ra + 32'(DEPTH);
            model(rop, rpfx, rsv, ra, rb, er, ee, eg, el);
            run_cmd(rop, rpfx, rsv, ra, rb, r, e, g, lat);
            check($sformatf("rnd%0d_op%0d_result", n, rop), r, er);
            check($sformatf("rnd%0d_op%0d_err", n, rop), {56'd0, e}, {56'd0, ee});
            check($sformatf("rnd%0d_op%0d_gp", n, rop), {63'd0, g}, {63'd0, eg});
            check($sformatf("rnd%0d_op%0d_latency", n, rop), 64'(lat), 64'(el));
        end

        // Start held high across three add commands.
        @(negedge clk);
        start = 1'b1; op = 8'd1; op_prefix = 1'b0; sv = 1'b0; A = 32'd10; B = 32'd20;
        pulses = 0; wide = 0; prev = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (prev != 0) wide++;
                check($sformatf("held_result%0d", pulses), result, 64'd30);
            end
            prev = int'(done);
        end
        @(negedge clk); start = 1'b0;
        check("held_pulses", 64'(pulses), 64'd3);
        check("held_wide_pulses", 64'(wide), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("held_no_extra_done", {63'd0, done}, 64'd0);

        // Reset during a divide.
        run_cmd(8'd7, 1'b0, 1'b0, 32'd7, 32'h66, r, e, g, lat);
        run_cmd(8'd10, 1'b0, 1'b0, 32'd7, 32'h77, r, e, g, lat);
        check("pre_reset_wmr_result", r, 64'h66);
        @(negedge clk);
        start = 1'b1; op = 8'd5; op_prefix = 1'b0; sv = 1'b0; A = 32'd100; B = 32'd3;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midreset_done", {63'd0, done}, 64'd0);
        check("midreset_result", result, 64'd0);
        check("midreset_err", {56'd0, err}, 64'd0);
        check("midreset_gp", {63'd0, gp}, 64'd0);
        @(negedge clk); reset = 1'b0;
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) spurious++;
        end
        check("midreset_no_done", 64'(spurious), 64'd0);
        run_cmd(8'd0, 1'b0, 1'b0, 32'd0, 32'd0, r, e, g, lat);
        check("post_reset_nop_latency", 64'(lat), 64'd1);
        check("post_reset_nop_result", r, 64'd0);
        run_cmd(8'd6, 1'b0, 1'b0, 32'd7, 32'd0, r, e, g, lat);
        check("post_reset_mem7", r, 64'd0);
        run_cmd(8'd6, 1'b0, 1'b0, 32'd4, 32'd0, r, e, g, lat);
        check("post_reset_mem4", r, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
